// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_t;

  // Holding register for one captured core request
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        we;
    logic [31:0] wd;
  } lsu_req_t;

  // Halfword at odd address, or word (incl. codes 3/6/7) not on a word boundary
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    if (size[1:0] == 2'b00)      is_misaligned = 1'b0;
    else if (size[1:0] == 2'b01) is_misaligned = addr_lo[0];
    else                         is_misaligned = (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane steering: store byte enables / data replication, load lane select / extension.
// Size codes with low bits 00 are byte, 01 halfword, anything else word.
module riscv_lsu_align (
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] rd_o
);
  logic             is_b, is_h, sext;
  logic [3:0][7:0]  wd_lanes, rd_lanes;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign is_b = (size_i[1:0] == 2'b00);
  assign is_h = (size_i[1:0] == 2'b01);
  assign sext = ~size_i[2];

  // Byte enables from size and low address bits
  always_comb begin
    be_o = 4'b1111;
    if (is_b)      be_o = 4'b0001 << addr_lo_i;
    else if (is_h) be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
  end

  for (genvar j = 0; j < 4; j++) begin : g_lane
    assign wd_lanes[j] = is_b ? wd_i[7:0] :
                         is_h ? wd_i[8*(j%2) +: 8] : wd_i[8*j +: 8];
  end
  assign wd_o = wd_lanes;

  assign rd_lanes = rd_i;
  assign byte_sel = rd_lanes[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? rd_i[31:16] : rd_i[15:0];

  // Load extension: signed for B/H, zero for BU/HU, word passes through
  always_comb begin
    rd_o = rd_i;
    if (is_b)      rd_o = {{24{sext & byte_sel[7]}}, byte_sel};
    else if (is_h) rd_o = {{16{sext & half_sel[15]}}, half_sel};
  end
endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the core data port and a word-addressed memory.
// Optional macro LSU_MISALIGN_CHK_EN: misaligned H/W accesses skip memory and
// report misalign_o in RESP; otherwise misalign_o stays 0.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        bus_err_o,
  output logic        misalign_o
);
  import riscv_lsu_pkg::*;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  lsu_req_t    req_q;
  logic [31:0] rdata_q;
  logic [15:0] cnt_q;
  logic        err_q, mis_q;
  logic [3:0]  be;
  logic [31:0] wd_rep, rd_ext;
  logic        timeout, misaligned;

  assign timeout = (cnt_q == CNT_MAX);

`ifdef LSU_MISALIGN_CHK_EN
  assign misaligned = is_misaligned(core_size_i, core_addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  riscv_lsu_align u_align (
    .size_i    (req_q.size),
    .addr_lo_i (req_q.addr[1:0]),
    .wd_i      (req_q.wd),
    .rd_i      (mem_rd_i),
    .be_o      (be),
    .wd_o      (wd_rep),
    .rd_o      (rd_ext)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, stall and memory request
  always_comb begin
    state_d      = state_q;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    case (state_q)
      IDLE: begin
        core_stall_o = core_req_i;
        if (core_req_i) state_d = misaligned ? RESP : BUSY;
      end
      BUSY: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        if (mem_ready_i || timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, timeout counter and response data/flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (core_req_i) begin
          req_q <= '{addr: core_addr_i, size: core_size_i, we: core_we_i, wd: core_wd_i};
          cnt_q <= '0;
          err_q <= 1'b0;
          mis_q <= misaligned;
          if (misaligned) rdata_q <= '0;
        end
        BUSY: begin
          cnt_q <= cnt_q + 16'd1;
          if (mem_ready_i) begin
            if (!req_q.we) rdata_q <= rd_ext;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o   = mem_req_o & req_q.we;
  assign mem_be_o   = mem_req_o ? be : 4'b0000;
  assign mem_addr_o = {req_q.addr[31:2], 2'b00};
  assign mem_wd_o   = wd_rep;
  assign core_rd_o  = rdata_q;
  assign bus_err_o  = (state_q == RESP) & err_q;
  assign misalign_o = (state_q == RESP) & mis_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (TIMEOUT_CYCLES=4).
module tb_riscv_lsu;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, core_rd_o;
  logic        core_stall_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i, bus_err_o, misalign_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i), .bus_err_o(bus_err_o),
    .misalign_o(misalign_o)
  );

  // Observations from one access
  logic        o_done, o_err, o_mis, o_we;
  int          o_stalls, o_nbusy;
  logic [31:0] o_rd, o_addr, o_wd;
  logic [3:0]  o_be;

  // Drives one access; ready asserted on BUSY cycle index ready_at (-1 = never)
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int ready_at);
    o_done = 0; o_stalls = 0; o_nbusy = 0; o_rd = '0; o_err = 0; o_mis = 0;
    o_we = 0; o_addr = '0; o_wd = '0; o_be = '0;
    @(negedge clk_i);
    core_req_i = 1; core_we_i = we; core_size_i = size; core_addr_i = addr;
    core_wd_i = wd; mem_rd_i = rd; mem_ready_i = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (core_stall_o) begin
        o_stalls++;
        if (mem_req_o) begin
          o_be = mem_be_o; o_addr = mem_addr_o; o_wd = mem_wd_o; o_we = mem_we_o;
          mem_ready_i = (o_nbusy == ready_at);
          o_nbusy++;
        end else mem_ready_i = 0;
      end else begin
        o_rd = core_rd_o; o_err = bus_err_o; o_mis = misalign_o;
        o_done = 1;
        break;
      end
      @(negedge clk_i);
    end
    core_req_i = 0; mem_ready_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0; core_req_i = 0; core_we_i = 0; core_size_i = 0; core_addr_i = 0;
    core_wd_i = 0; mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 0;
    #1;
    checks++;
    if ({core_stall_o, mem_req_o, mem_we_o, mem_be_o, bus_err_o, misalign_o} !== 9'd0 ||
        core_rd_o !== 0 || mem_addr_o !== 0 || mem_wd_o !== 0) begin
      errors++; $display("FAIL reset_outputs: stall=%b req=%b rd=%h addr=%h wd=%h be=%b, required all 0",
                         core_stall_o, mem_req_o, core_rd_o, mem_addr_o, mem_wd_o, mem_be_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_store();
    access(1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 0, 0);
    checks++;
    if (!o_done || o_stalls != 2 || o_addr !== 32'h100 || o_be !== 4'b1000 ||
        o_wd !== 32'hA5A5_A5A5 || o_we !== 1) begin
      errors++; $display("FAIL sb: done=%0d stalls=%0d addr=%h be=%b wd=%h we=%b, required 1 2 100 1000 a5a5a5a5 1",
                         o_done, o_stalls, o_addr, o_be, o_wd, o_we);
    end
    access(1, 3'd1, 32'h0000_0102, 32'hFFFF_1234, 0, 0);
    checks++;
    if (o_be !== 4'b1100 || o_wd !== 32'h1234_1234 || o_addr !== 32'h100) begin
      errors++; $display("FAIL sh: be=%b wd=%h addr=%h, required 1100 12341234 100", o_be, o_wd, o_addr);
    end
    access(1, 3'd2, 32'h0000_0208, 32'hDEAD_BEEF, 0, 0);
    checks++;
    if (o_be !== 4'b1111 || o_wd !== 32'hDEAD_BEEF || o_addr !== 32'h208) begin
      errors++; $display("FAIL sw: be=%b wd=%h addr=%h, required 1111 deadbeef 208", o_be, o_wd, o_addr);
    end
    access(1, 3'd3, 32'h0000_0100, 32'h0102_0304, 0, 0);
    checks++;
    if (o_be !== 4'b1111 || o_wd !== 32'h0102_0304) begin
      errors++; $display("FAIL size3_as_w: be=%b wd=%h, required 1111 01020304", o_be, o_wd);
    end
  endtask

  task automatic test_load();
    logic [2:0]  sz  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] ad  [5] = '{32'h202, 32'h202, 32'h302, 32'h302, 32'h300};
    logic [31:0] mr  [5] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_1234, 32'h8001_1234, 32'h8001_1234};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_1234};
    for (int k = 0; k < 5; k++) begin
      access(0, sz[k], ad[k], 32'h0, mr[k], 0);
      checks++;
      if (!o_done || o_rd !== exp[k] || o_we !== 0 || o_stalls != 2 || o_err !== 0) begin
        errors++; $display("FAIL load%0d: rd=%h we=%b stalls=%0d err=%b, required rd=%h we=0 stalls=2 err=0",
                           k, o_rd, o_we, o_stalls, o_err, exp[k]);
      end
    end
    // Store must not disturb the last load result
    access(1, 3'd2, 32'h400, 32'h5555_AAAA, 32'h1111_1111, 0);
    checks++;
    if (o_rd !== 32'h8001_1234) begin
      errors++; $display("FAIL store_keeps_rdata: rd=%h, required 80011234", o_rd);
    end
  endtask

  task automatic test_back_to_back();
    access(0, 3'd2, 32'h500, 0, 32'hCAFE_0001, 2);
    checks++;
    if (o_stalls != 4 || o_nbusy != 3 || o_rd !== 32'hCAFE_0001) begin
      errors++; $display("FAIL delayed_ready: stalls=%0d busy=%0d rd=%h, required 4 3 cafe0001",
                         o_stalls, o_nbusy, o_rd);
    end
    access(0, 3'd4, 32'h501, 0, 32'h0000_9900, 0);
    checks++;
    if (o_stalls != 2 || o_rd !== 32'h0000_0099) begin
      errors++; $display("FAIL back_to_back: stalls=%0d rd=%h, required 2 00000099", o_stalls, o_rd);
    end
  endtask

  task automatic test_timeout();
    access(0, 3'd2, 32'h600, 0, 32'h1234_5678, -1);
    checks++;
    if (!o_done || o_nbusy != 4 || o_stalls != 5 || o_err !== 1 || o_rd !== 0) begin
      errors++; $display("FAIL timeout: done=%0d busy=%0d stalls=%0d err=%b rd=%h, required 1 4 5 1 0",
                         o_done, o_nbusy, o_stalls, o_err, o_rd);
    end
    @(negedge clk_i); #1;
    checks++;
    if (bus_err_o !== 0) begin
      errors++; $display("FAIL timeout_pulse_len: bus_err=%b, required 0", bus_err_o);
    end
  endtask

  task automatic test_async_reset();
    access(0, 3'd2, 32'h700, 0, 32'h7777_7777, 0);
    @(negedge clk_i);
    core_req_i = 1; core_we_i = 1; core_size_i = 3'd2; core_addr_i = 32'h10C;
    core_wd_i = 32'hCAFE_F00D; mem_ready_i = 0;
    @(negedge clk_i); #1;
    checks++;
    if (mem_req_o !== 1 || mem_wd_o !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL pre_reset_busy: req=%b wd=%h, required 1 cafef00d", mem_req_o, mem_wd_o);
    end
    core_req_i = 0; rst_ni = 0; #1;
    checks++;
    if ({core_stall_o, mem_req_o, mem_we_o, mem_be_o, bus_err_o, misalign_o} !== 9'd0 ||
        core_rd_o !== 0 || mem_addr_o !== 0 || mem_wd_o !== 0) begin
      errors++; $display("FAIL async_reset: stall=%b req=%b rd=%h addr=%h wd=%h be=%b, required all 0",
                         core_stall_o, mem_req_o, core_rd_o, mem_addr_o, mem_wd_o, mem_be_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (bus_err_o !== 0 || core_stall_o !== 0) begin
      errors++; $display("FAIL reset_no_pulse: err=%b stall=%b, required 0 0", bus_err_o, core_stall_o);
    end
    rst_ni = 1;
    access(0, 3'd1, 32'h302, 0, 32'h8001_1234, 0);
    checks++;
    if (!o_done || o_stalls != 2 || o_rd !== 32'hFFFF_8001) begin
      errors++; $display("FAIL after_reset: stalls=%0d rd=%h, required 2 ffff8001", o_stalls, o_rd);
    end
  endtask

  task automatic test_misalign();
    access(0, 3'd2, 32'h101, 0, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_CHK_EN
    checks++;
    if (!o_done || o_nbusy != 0 || o_stalls != 1 || o_mis !== 1 || o_rd !== 0) begin
      errors++; $display("FAIL misalign_w: busy=%0d stalls=%0d mis=%b rd=%h, required 0 1 1 0",
                         o_nbusy, o_stalls, o_mis, o_rd);
    end
    @(negedge clk_i); #1;
    checks++;
    if (misalign_o !== 0) begin
      errors++; $display("FAIL misalign_pulse_len: mis=%b, required 0", misalign_o);
    end
`else
    checks++;
    if (o_nbusy != 1 || o_addr !== 32'h100 || o_be !== 4'b1111 || o_mis !== 0 || o_rd !== 32'h1122_3344) begin
      errors++; $display("FAIL unaligned_w: busy=%0d addr=%h be=%b mis=%b rd=%h, required 1 100 1111 0 11223344",
                         o_nbusy, o_addr, o_be, o_mis, o_rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit directly downstream of the core's data-memory port. It takes the core's memory request (addr, size, we, wdata) and drives a word-addressed data memory with byte enables and a ready handshake. It returns sign- or zero-extended load data and holds the core with a stall until the access completes. Its outputs feed the core's stall and load-data inputs.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in BUSY waiting for mem_ready_i before the access is aborted (range 1..65535).

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
core_req_i  in  1  core requests a memory access; held while core_stall_o=1
core_we_i  in  1  1=store, 0=load
core_size_i  in  3  funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
core_addr_i  in  32  byte address
core_wd_i  in  32  store data, value in low bits
core_rd_o  out  32  extended load data, valid in RESP
core_stall_o  out  1  freeze core
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word-aligned address
mem_wd_o  out  32  lane-replicated store data
mem_rd_i  in  32  memory read word
mem_ready_i  in  1  memory completes the access this cycle
bus_err_o  out  1  one-cycle pulse on timeout
misalign_o  out  1  one-cycle pulse on misaligned access (optional feature)

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; every output 0; holding registers and timeout counter 0.
- IDLE: core_stall_o = core_req_i (combinational). On core_req_i, capture addr/size/we/wd at the edge and go to BUSY.
- BUSY: mem_req_o=1, core_stall_o=1. Memory outputs come only from the holding registers. Counter increments each cycle. On mem_ready_i: latch extended load data into rdata_q (stores leave rdata_q unchanged) and go to RESP. If the counter reaches TIMEOUT_CYCLES-1 without ready: rdata_q=0, set err flag, go to RESP.
- RESP: core_stall_o=0, core_rd_o=rdata_q, bus_err_o=err flag, mem_req_o=0. Always returns to IDLE next cycle; the core retires at this edge. A new core_req_i in the following cycle starts a fresh access.
- Latency: with ready on the first BUSY cycle, an access stalls 2 cycles and core_rd_o is valid on cycle 3.
- mem_addr_o = {addr[31:2],2'b00}. mem_be_o and mem_we_o are 0 when mem_req_o=0.
- Stores:
  - B: be = 4'b0001<<addr[1:0]; wd = {4{wd[7:0]}}.
  - H: be = 4'b0011<<{addr[1],1'b0}; wd = {2{wd[15:0]}}.
  - W: be = 4'b1111; wd = wd.
- Loads: select byte lane addr[1:0] or half lane addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Size codes 3/6/7 are treated as W.
- core_req_i dropping while in BUSY is ignored; the access completes.
- mem_ready_i outside BUSY is ignored.
- rst_ni asserted mid-access aborts it immediately; no pulse is generated.

Optional Feature:
LSU_MISALIGN_CHK_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, skips BUSY. The LSU goes IDLE->RESP with no memory request, rdata_q=0, and misalign_o=1 for the RESP cycle.
- Undefined: misalign_o is tied 0. H uses addr[1] only; W ignores addr[1:0].

Decomposition:
- riscv_lsu_pkg holds:
  - size constants LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5;
  - state enum lsu_state_t {IDLE, BUSY, RESP}.
- One combinational sub-module, riscv_lsu_align, does store lane steering/byte-enable generation and load lane select/extension.

Test Plan:
- SB addr=0x0000_0103, wd=0x0000_00A5, ready on first BUSY cycle -> mem_addr_o=0x100, be=4'b1000, wd=0xA5A5_A5A5; stall high 2 cycles, low on cycle 3.
- LB addr=0x202, mem_rd_i=0x0080_0000 -> core_rd_o=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- LH addr=0x302, mem_rd_i=0x8001_1234 -> 0xFFFF_8001. LHU -> 0x0000_8001. LW -> 0x8001_1234.
- TIMEOUT_CYCLES=4, mem_ready_i held 0 -> 4 BUSY cycles, then RESP with bus_err_o=1 for one cycle and core_rd_o=0.
- rst_ni pulsed low mid-BUSY -> all outputs 0 asynchronously. The next access after reset behaves normally.
- With LSU_MISALIGN_CHK_EN, LW addr=0x101 -> mem_req_o never asserted, one stall cycle, misalign_o=1 in RESP, core_rd_o=0.
